// File: rtl/id_stage_hazard.sv
// MIPS decode stage: register file with write-through bypass, sign extend, branch target,
// load-use hazard stall/bubble, flush, and ID/EX register. Optional stall counter: ID_STALL_CNT_EN.
module id_stage_hazard #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 11,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [31:0]           instruction,
    input  logic [PC_W-1:0]       current_pc,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     write_back_data,
    input  logic [REG_ADDR_W-1:0] write_back_address,
    input  logic                  RegWrite,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_reg_dest,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     data_a,
    output logic [DATA_W-1:0]     data_b,
    output logic [DATA_W-1:0]     sign_extended,
    output logic [PC_W-1:0]       jump_dest_addr,
    output logic [REG_ADDR_W-1:0] reg_dest_r_type,
    output logic [REG_ADDR_W-1:0] reg_dest_l_type,
`ifdef ID_STALL_CNT_EN
    output logic [15:0]           stall_count,
`endif
    output logic [REG_ADDR_W-1:0] rs_addr
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]     rs_val, rt_val, sext;
    logic [PC_W-1:0]       offset, target;
    logic                  unused_opcode;

    assign rs = instruction[21 +: REG_ADDR_W];
    assign rt = instruction[16 +: REG_ADDR_W];
    assign rd = instruction[11 +: REG_ADDR_W];
    assign unused_opcode = ^instruction[31:21+REG_ADDR_W];

    // Register 0 is hard-wired to zero; a same-cycle write-back is passed straight through.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rs_val = regs[rs];
        rt_val = regs[rt];
        if (rs == '0)
            rs_val = '0;
        else if (RegWrite && (rs == write_back_address))
            rs_val = write_back_data;
        if (rt == '0)
            rt_val = '0;
        else if (RegWrite && (rt == write_back_address))
            rt_val = write_back_data;
    end

    assign sext   = {{(DATA_W-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};
    assign offset = sext[PC_W-1:0] << 2;
    assign target = current_pc + offset;

    // A flush kills the consumer, so there is nothing left to stall for.
    assign stall = !flush && id_valid && ex_valid && ex_mem_read && (ex_reg_dest != '0) &&
                   ((ex_reg_dest == rs) || (ex_reg_dest == rt));

    // NOTE: the register array sits under the async reset because every register must read 0 after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (RegWrite && (write_back_address != '0)) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            regs[write_back_address] <= write_back_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid        <= 1'b0;
            data_a          <= '0;
            data_b          <= '0;
            sign_extended   <= '0;
            jump_dest_addr  <= '0;
            reg_dest_r_type <= '0;
            reg_dest_l_type <= '0;
            rs_addr         <= '0;
        end else if (flush || stall) begin
            ex_valid <= 1'b0;
        end else begin
            ex_valid        <= id_valid;
            data_a          <= rs_val;
            data_b          <= rt_val;
            sign_extended   <= sext;
            jump_dest_addr  <= target;
            reg_dest_r_type <= rd;
            reg_dest_l_type <= rt;
            rs_addr         <= rs;
        end
    end

`ifdef ID_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_count <= '0;
        else if (stall && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end
`endif

endmodule
